dmem_responder: RTL

Memory-side responder for the data memory request interface. Requests come from the load/store queue as address, data, read/write flag and 4-bit ld/st ID. The block buffers them in an in-order request queue and services them one at a time against a 4 KB word-addressed array with a fixed access latency. Each completion is returned with its ID on a one-cycle `ready_out` pulse. `stall_out` is asserted while the queue cannot accept another request. The block replaces the ad-hoc delay-line data cache as the D-side endpoint of the load/store queue.

---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the load/store queue and the data-memory responder.
// Handshake: a request transfers on a rising edge where valid_in=1 and stall_out=0; the
// initiator holds addr/data/rw/id stable until then. ready_out is a one-cycle pulse
// qualifying data_out/id_out, with no back-pressure on the response side.
interface dmem_if;
   logic [31:0] addr_in;
   logic [31:0] data_in;
   logic        rw_in;
   logic [3:0]  id_in;
   logic        valid_in;
   logic [31:0] data_out;
   logic [3:0]  id_out;
   logic        ready_out;
   logic        stall_out;

   modport master (
      output addr_in, data_in, rw_in, id_in, valid_in,
      input  data_out, id_out, ready_out, stall_out
   );

   modport slave (
      input  addr_in, data_in, rw_in, id_in, valid_in,
      output data_out, id_out, ready_out, stall_out
   );
endinterface

// File: rtl/dmem_responder.sv
// In-order data-memory responder: request queue feeding a fixed-latency engine
// over a 1024 x 32-bit word array.
module dmem_responder #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   dmem_if.slave                  bus,
   output logic                   dbg_state,
   output logic [$clog2(DEPTH):0] dbg_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;

   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;
   logic [9:0]       q_idx  [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic             q_rw   [DEPTH];
   logic [3:0]       q_id   [DEPTH];

   logic [31:0]      mem [1024];
   logic [31:0]      cap_data;
   logic [3:0]       cap_id;

   logic             push, pop, resp;
   logic             unused_addr;

   // Only the word index participates in addressing.
   assign unused_addr = ^{bus.addr_in[31:12], bus.addr_in[1:0]};

   assign bus.stall_out = (count == (PTR_W+1)'(DEPTH));
   assign push          = bus.valid_in && !bus.stall_out;
   assign dbg_state     = state;
   assign dbg_count     = count;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (count != '0) state_nxt = BUSY;
         BUSY: if (cnt == '0 && count == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A finishing service and the next pop share one edge so throughput is one per LATENCY.
   always_comb begin
      pop  = 1'b0;
      resp = 1'b0;
      case (state)
         IDLE: pop = (count != '0);
         BUSY: begin
            if (cnt == '0) begin
               resp = 1'b1;
               pop  = (count != '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                             cnt <= '0;
      else if (pop)                        cnt <= CNT_W'(LATENCY - 1);
      else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            q_idx[tail]  <= bus.addr_in[11:2];
            q_data[tail] <= bus.data_in;
            q_rw[tail]   <= bus.rw_in;
            q_id[tail]   <= bus.id_in;
            tail         <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The array access happens at service start; the result waits in cap_* for the response edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         cap_data <= '0;
         cap_id   <= '0;
      end else if (pop) begin
         if (q_rw[head]) begin
            mem[q_idx[head]] <= q_data[head];
            cap_data         <= q_data[head];
         end else begin
            cap_data <= mem[q_idx[head]];
         end
         cap_id <= q_id[head];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ready_out <= 1'b0;
         bus.data_out  <= '0;
         bus.id_out    <= '0;
      end else begin
         bus.ready_out <= resp;
         if (resp) begin
            bus.data_out <= cap_data;
            bus.id_out   <= cap_id;
         end
      end
   end

endmodule
